// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: round-robin arbiter and sequencer for a small memory made of
// NUM_LINES single-byte lines that share read/write enables and a read bus.
// Each transaction runs IDLE -> ACCESS -> RESP. The line access happens in
// ACCESS, and the granted port gets a one-cycle ack in RESP.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   req0/we0/addr0/wdata0/ack0   requester port 0 (req held until ack)
//   req1/we1/addr1/wdata1/ack1   requester port 1
//   rdata                        captured read data, valid in ack cycle, held
//   err                          pulses with ack for out-of-range addresses
//   busy                         high outside IDLE
//   line_select                  one-hot line select (ACCESS only)
//   read_en, write_en            shared line enables (ACCESS only)
//   mem_wdata                    shared write data bus (holds last value)
//   mem_rdata                    shared read bus from the lines
module line_mem_arbiter #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [DATA_W-1:0]    wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_W-1:0]    wdata1,
  output logic                 ack1,
  output logic [DATA_W-1:0]    rdata,
  output logic                 err,
  output logic                 busy,
  output logic [NUM_LINES-1:0] line_select,
  output logic                 read_en,
  output logic                 write_en,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] LINES_C = (ADDR_W+1)'(NUM_LINES);

  state_t               state_q;
  logic                 last_grant_q;
  logic                 gnt_q;
  logic                 we_q;
  logic                 in_range_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic                 err_q;
  logic                 busy_q;
  logic                 read_en_q;
  logic                 write_en_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic [NUM_LINES-1:0] line_select_q;

  logic                 gnt_d;
  logic                 we_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic                 in_range_d;
  logic [NUM_LINES-1:0] sel_d;

  // Winner selection and address decode for the candidate grant.
  always_comb begin
    gnt_d      = (req0 && req1) ? ~last_grant_q : req1;
    we_d       = gnt_d ? we1    : we0;
    addr_d     = gnt_d ? addr1  : addr0;
    wdata_d    = gnt_d ? wdata1 : wdata0;
    in_range_d = ({1'b0, addr_d} < LINES_C);
    sel_d      = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (addr_d == ADDR_W'(i)) sel_d[i] = 1'b1;
    end
  end

  // The address and write data are consumed at grant time: the decoded select
  // and range flag are latched instead of the raw address, and the write data
  // is loaded straight into mem_wdata, which then holds it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      we_q          <= 1'b0;
      in_range_q    <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      read_en_q     <= 1'b0;
      write_en_q    <= 1'b0;
      rdata_q       <= '0;
      mem_wdata_q   <= '0;
      line_select_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q         <= gnt_d;
            last_grant_q  <= gnt_d;
            we_q          <= we_d;
            in_range_q    <= in_range_d;
            busy_q        <= 1'b1;
            line_select_q <= sel_d;
            read_en_q     <= ~we_d;
            write_en_q    <= we_d;
            if (we_d) mem_wdata_q <= wdata_d;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          line_select_q <= '0;
          read_en_q     <= 1'b0;
          write_en_q    <= 1'b0;
          if (!we_q) rdata_q <= in_range_q ? mem_rdata : '0;
          ack0_q        <= ~gnt_q;
          ack1_q        <= gnt_q;
          err_q         <= ~in_range_q;
          state_q       <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign line_select = line_select_q;
  assign read_en     = read_en_q;
  assign write_en    = write_en_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
